// File: rtl/pe_launch_pkg.sv
// Shared types and constants for the PE launch controller.
package pe_launch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    localparam logic [1:0] CFG_MASK = 2'd0;
    localparam logic [1:0] CFG_ITER = 2'd1;
    localparam logic [1:0] CFG_TMO  = 2'd2;

endpackage

// File: rtl/pe_launch_watchdog.sv
// Per-iteration RUN cycle counter; flags expiry when the counted cycles reach a nonzero limit
// while PEs are still pending. Counter clears whenever the controller is outside RUN.
module pe_launch_watchdog #(
    parameter int TMO_WIDTH = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [TMO_WIDTH-1:0] limit,
    input  logic                 pending_any,
    output logic                 expire
);

    logic [TMO_WIDTH-1:0] cnt_q;
    logic [TMO_WIDTH-1:0] cnt_d;
    logic [TMO_WIDTH-1:0] cnt_inc;

    always_comb begin
        cnt_inc = cnt_q + 1'b1;
        cnt_d   = run ? cnt_inc : '0;
    end

    // cnt_inc is the number of RUN cycles including the current one
    assign expire = run && pending_any && (limit != '0) && (cnt_inc == limit);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pe_launch_ctrl.sv
// Launch controller: runs N iterations of start/done handshakes over a masked set of PE slots;
// start and busy follow go by one cycle. Optional watchdog under `PE_LAUNCH_TIMEOUT_EN`.
module pe_launch_ctrl
    import pe_launch_pkg::*;
#(
    parameter int NUM_PE     = 4,
    parameter int ITER_WIDTH = 16,
    parameter int TMO_WIDTH  = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_wr_en,
    input  logic [1:0]            cfg_addr,
    input  logic [31:0]           cfg_data,
    input  logic                  go,
    input  logic                  abort,
    input  logic [NUM_PE-1:0]     pe_ap_done,
    output logic [NUM_PE-1:0]     pe_ap_start,
    output logic                  busy,
    output logic                  done,
    output logic [ITER_WIDTH-1:0] iter_count,
    output logic                  timeout,
    output logic [NUM_PE-1:0]     timeout_mask
);

    state_e                state_q, state_d;
    logic [NUM_PE-1:0]     mask_q, mask_d;
    logic [NUM_PE-1:0]     pending_q, pending_d;
    logic [NUM_PE-1:0]     start_q, start_d;
    logic [ITER_WIDTH-1:0] iter_cfg_q, iter_cfg_d;
    logic [ITER_WIDTH-1:0] iter_count_q, iter_count_d;
    logic [ITER_WIDTH-1:0] iter_inc;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  cfg_ok;
    logic                  go_accept;
    logic                  expire;
    logic                  unused_cfg;

    assign cfg_ok     = cfg_wr_en && (state_q == ST_IDLE);
    assign go_accept  = (state_q == ST_IDLE) && go && !abort;
    assign unused_cfg = ^cfg_data;

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        iter_cfg_d   = iter_cfg_q;
        pending_d    = pending_q;
        start_d      = start_q;
        iter_count_d = iter_count_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        iter_inc     = (&iter_count_q) ? iter_count_q : iter_count_q + 1'b1;

        if (cfg_ok) begin
            case (cfg_addr)
                CFG_MASK: mask_d     = cfg_data[NUM_PE-1:0];
                CFG_ITER: iter_cfg_d = cfg_data[ITER_WIDTH-1:0];
                default:  ;
            endcase
        end

        if ((state_q != ST_IDLE) && abort) begin
            state_d   = ST_IDLE;
            pending_d = '0;
            start_d   = '0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (go_accept) begin
                        if ((mask_q != '0) && (iter_cfg_q != '0)) begin
                            pending_d    = mask_q;
                            start_d      = mask_q;
                            iter_count_d = '0;
                            busy_d       = 1'b1;
                            state_d      = ST_RUN;
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_FIN;
                        end
                    end
                end
                ST_RUN: begin
                    if (expire) begin
                        pending_d = '0;
                        start_d   = '0;
                        busy_d    = 1'b0;
                        state_d   = ST_IDLE;
                    end else if (pending_q == '0) begin
                        iter_count_d = iter_inc;
                        if (iter_inc >= iter_cfg_q) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = ST_FIN;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else begin
                        // start tracks pending so each PE drops start right after its own done
                        pending_d = pending_q & ~pe_ap_done;
                        start_d   = start_q & ~pe_ap_done;
                    end
                end
                ST_GAP: begin
                    pending_d = mask_q;
                    start_d   = mask_q;
                    state_d   = ST_RUN;
                end
                ST_FIN: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mask_q       <= '0;
            iter_cfg_q   <= '0;
            pending_q    <= '0;
            start_q      <= '0;
            iter_count_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            iter_cfg_q   <= iter_cfg_d;
            pending_q    <= pending_d;
            start_q      <= start_d;
            iter_count_q <= iter_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

`ifdef PE_LAUNCH_TIMEOUT_EN
    logic [TMO_WIDTH-1:0] tmo_limit_q, tmo_limit_d;
    logic                 timeout_q, timeout_d;
    logic [NUM_PE-1:0]    tmo_mask_q, tmo_mask_d;

    pe_launch_watchdog #(
        .TMO_WIDTH (TMO_WIDTH)
    ) u_watchdog (
        .clk         (clk),
        .reset       (reset),
        .run         (state_q == ST_RUN),
        .limit       (tmo_limit_q),
        .pending_any (|pending_q),
        .expire      (expire)
    );

    always_comb begin
        tmo_limit_d = tmo_limit_q;
        if (cfg_ok && (cfg_addr == CFG_TMO)) begin
            tmo_limit_d = cfg_data[TMO_WIDTH-1:0];
        end
        timeout_d  = expire && !abort;
        tmo_mask_d = tmo_mask_q;
        if (go_accept) begin
            tmo_mask_d = '0;
        end else if (timeout_d) begin
            tmo_mask_d = pending_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_limit_q <= '0;
            timeout_q   <= 1'b0;
            tmo_mask_q  <= '0;
        end else begin
            tmo_limit_q <= tmo_limit_d;
            timeout_q   <= timeout_d;
            tmo_mask_q  <= tmo_mask_d;
        end
    end

    assign timeout      = timeout_q;
    assign timeout_mask = tmo_mask_q;
`else
    logic [TMO_WIDTH-1:0] unused_tmo;

    assign unused_tmo   = '0;
    assign expire       = 1'b0;
    assign timeout      = 1'b0;
    assign timeout_mask = '0;
`endif

    assign pe_ap_start = start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign iter_count  = iter_count_q;

endmodule

// File: tb/tb_pe_launch_ctrl.sv
// Bench for pe_launch_ctrl: event-scheduled reference model, per-cycle compare, directed and random runs.
module tb_pe_launch_ctrl;

    localparam int NEVER = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_wr_en = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [31:0] cfg_data = '0;
    logic        go = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  pe_ap_done;
    logic [3:0]  pe_ap_start;
    logic        busy;
    logic        done;
    logic [15:0] iter_count;
    logic        timeout;
    logic [3:0]  timeout_mask;

    logic [3:0]  auto_done = '0;
    logic [3:0]  spur_done = '0;
    assign pe_ap_done = auto_done | spur_done;

    pe_launch_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .go           (go),
        .abort        (abort),
        .pe_ap_done   (pe_ap_done),
        .pe_ap_start  (pe_ap_start),
        .busy         (busy),
        .done         (done),
        .iter_count   (iter_count),
        .timeout      (timeout),
        .timeout_mask (timeout_mask)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, now);
        end
    endtask

    // ---------------- reference model (event schedule per the timing rules) ----------------
    int          now = 0;
    logic        m_run = 1'b0;
    logic [3:0]  m_mask = '0;
    logic [3:0]  m_pending = '0;
    logic [15:0] m_iters = '0;
    logic [19:0] m_limit = '0;
    int          fin_at = -1;
    int          detect_at = -1;
    int          reload_at = -1;
    int          entry = 0;
    logic        idle_now;
    logic [3:0]  x_start = '0;
    logic        x_busy = 1'b0;
    logic        x_done = 1'b0;
    logic [15:0] x_iter = '0;
    logic        x_tmo = 1'b0;
    logic [3:0]  x_tmask = '0;

    always @(posedge clk) begin
        x_done = 1'b0;
        x_tmo  = 1'b0;
        if (reset) begin
            m_run = 1'b0; m_mask = '0; m_pending = '0; m_iters = '0; m_limit = '0;
            fin_at = -1; detect_at = -1; reload_at = -1;
            x_start = '0; x_busy = 1'b0; x_iter = '0; x_tmask = '0;
        end else begin
            idle_now = !m_run && (now != fin_at);
            if (idle_now && cfg_wr_en) begin
                if (cfg_addr == 2'd0) m_mask = cfg_data[3:0];
                if (cfg_addr == 2'd1) m_iters = cfg_data[15:0];
`ifdef PE_LAUNCH_TIMEOUT_EN
                if (cfg_addr == 2'd2) m_limit = cfg_data[19:0];
`endif
            end
            if (abort && !idle_now) begin
                m_run = 1'b0; m_pending = '0; x_start = '0; x_busy = 1'b0;
            end else if (idle_now && go && !abort) begin
                x_tmask = '0;
                if (m_mask != 0 && m_iters != 0) begin
                    m_run = 1'b1; m_pending = m_mask; x_start = m_mask;
                    x_iter = '0; x_busy = 1'b1; entry = now + 1;
                end else begin
                    x_done = 1'b1; fin_at = now + 1;
                end
            end else if (m_run) begin
                if (now == detect_at) begin
                    x_iter = x_iter + 1'b1;
                    if (x_iter == m_iters) begin
                        m_run = 1'b0; x_busy = 1'b0; x_done = 1'b1; fin_at = now + 1;
                    end else begin
                        reload_at = now + 1;
                    end
                end else if (now == reload_at) begin
                    m_pending = m_mask; x_start = m_mask; entry = now + 1;
`ifdef PE_LAUNCH_TIMEOUT_EN
                end else if (m_limit != 0 && now == entry + int'(m_limit) - 1) begin
                    x_tmo = 1'b1; x_tmask = m_pending;
                    m_run = 1'b0; m_pending = '0; x_start = '0; x_busy = 1'b0;
`endif
                end else begin
                    m_pending = m_pending & ~pe_ap_done;
                    x_start   = m_pending;
                    if (m_pending == 0) detect_at = now + 1;
                end
            end
        end
        now++;
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (now > 0) begin
            chk("pe_ap_start", 32'(pe_ap_start), 32'(x_start));
            chk("busy", 32'(busy), 32'(x_busy));
            chk("done", 32'(done), 32'(x_done));
            chk("iter_count", 32'(iter_count), 32'(x_iter));
            chk("timeout", 32'(timeout), 32'(x_tmo));
            chk("timeout_mask", 32'(timeout_mask), 32'(x_tmask));
        end
    end

    // ---------------- PE responders ----------------
    logic rand_mode = 1'b0;
    int   lat_cfg [4] = '{5, 5, 5, 5};
    int   lat_cur [4] = '{0, 0, 0, 0};
    int   age     [4] = '{0, 0, 0, 0};

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (pe_ap_start[i] === 1'b1) begin
                if (age[i] == 0) lat_cur[i] = rand_mode ? int'($urandom_range(0, 5)) : lat_cfg[i];
                age[i]++;
                auto_done[i] = (lat_cur[i] != NEVER) && (age[i] == lat_cur[i] + 1);
            end else begin
                age[i] = 0;
                auto_done[i] = 1'b0;
            end
        end
    end

    // ---------------- event monitor ----------------
    int n_done = 0;
    int last_done_cyc = -1;
    int last_tmo_cyc = -1;

    initial forever begin
        @(negedge clk);
        if (done === 1'b1) begin n_done++; last_done_cyc = now; end
        if (timeout === 1'b1) last_tmo_cyc = now;
    end

    // ---------------- stimulus ----------------
    int go_cyc;
    int done_snap;

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_wr_en = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_wr_en = 1'b0;
    endtask

    task automatic pulse_go();
        go = 1'b1; go_cyc = now;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= budget) begin
            errors++;
            $display("FAIL %s: busy still high after %0d cycles, expected idle", nm, budget);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "bench time limit");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_state", {pe_ap_start, busy, done, timeout, timeout_mask, iter_count}, 32'h0);

        // two iterations over PE0/PE2, done 5 cycles after each start
        cfg_write(2'd0, 32'h5);
        cfg_write(2'd1, 32'd2);
        done_snap = n_done;
        pulse_go();
        chk("t1_start_after_go", 32'(pe_ap_start), 32'h5);
        chk("t1_busy_after_go", 32'(busy), 32'h1);
        wait_idle(60, "t1_wait");
        chk("t1_iter_count", 32'(iter_count), 32'd2);
        chk("t1_done_pulses", 32'(n_done - done_snap), 32'd1);
        chk("t1_done_cycle", 32'(last_done_cyc - go_cyc), 32'd16);

        // all four PEs, staggered dones
        cfg_write(2'd0, 32'hF);
        cfg_write(2'd1, 32'd1);
        lat_cfg = '{3, 4, 7, 9};
        pulse_go();
        chk("t2_start_after_go", 32'(pe_ap_start), 32'hF);
        wait_idle(60, "t2_wait");
        chk("t2_done_cycle", 32'(last_done_cyc - go_cyc), 32'd12);

        // zero mask: immediate done, nothing started
        cfg_write(2'd0, 32'h0);
        pulse_go();
        chk("t3_zero_done", 32'(done), 32'h1);
        chk("t3_zero_busy", 32'(busy), 32'h0);
        chk("t3_zero_start", 32'(pe_ap_start), 32'h0);
        repeat (2) @(negedge clk);

        // config writes while busy are dropped
        cfg_write(2'd0, 32'h3);
        cfg_write(2'd1, 32'd3);
        lat_cfg = '{5, 5, 5, 5};
        pulse_go();
        cfg_write(2'd0, 32'hF);
        cfg_write(2'd1, 32'd1);
        wait_idle(80, "t3_wait");
        chk("t3_iter_kept", 32'(iter_count), 32'd3);
        pulse_go();
        chk("t3_mask_kept", 32'(pe_ap_start), 32'h3);
        wait_idle(80, "t3_wait2");

        // abort mid-run with both PEs pending
        cfg_write(2'd1, 32'd1);
        lat_cfg = '{NEVER, NEVER, NEVER, NEVER};
        done_snap = n_done;
        pulse_go();
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t4_abort_start", 32'(pe_ap_start), 32'h0);
        chk("t4_abort_busy", 32'(busy), 32'h0);
        chk("t4_abort_iter", 32'(iter_count), 32'h0);
        repeat (3) @(negedge clk);
        chk("t4_abort_no_done", 32'(n_done - done_snap), 32'd0);
        lat_cfg = '{2, 2, 2, 2};
        pulse_go();
        wait_idle(40, "t4_rerun");
        chk("t4_rerun_iter", 32'(iter_count), 32'd1);

        // spurious done on disabled PE2
        lat_cfg = '{4, 6, 1, 1};
        pulse_go();
        @(negedge clk);
        spur_done = 4'b0100;
        @(negedge clk);
        spur_done = 4'b0000;
        wait_idle(40, "t5_wait");
        chk("t5_done_cycle", 32'(last_done_cyc - go_cyc), 32'd9);

        // go with abort in idle
        done_snap = n_done;
        go = 1'b1; abort = 1'b1;
        @(negedge clk);
        go = 1'b0; abort = 1'b0;
        chk("t5_go_abort_busy", 32'(busy), 32'h0);
        chk("t5_go_abort_start", 32'(pe_ap_start), 32'h0);
        @(negedge clk);
        chk("t5_go_abort_done", 32'(n_done - done_snap), 32'd0);

`ifdef PE_LAUNCH_TIMEOUT_EN
        // watchdog: PE1 never finishes
        cfg_write(2'd2, 32'd8);
        lat_cfg = '{2, NEVER, 2, 2};
        done_snap = n_done;
        pulse_go();
        wait_idle(40, "t6_wait");
        chk("t6_tmo_cycle", 32'(last_tmo_cyc - go_cyc), 32'd9);
        chk("t6_tmo_mask", 32'(timeout_mask), 32'h2);
        chk("t6_no_done", 32'(n_done - done_snap), 32'd0);
        cfg_write(2'd2, 32'd0);
`endif

        // randomized runs
        rand_mode = 1'b1;
        for (int r = 0; r < 60; r++) begin
            if ($urandom_range(0, 1) == 1) cfg_write(2'd0, 32'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1) cfg_write(2'd1, 32'($urandom_range(0, 3)));
            if ($urandom_range(0, 4) == 0) cfg_write(2'd2, 32'($urandom_range(0, 12)));
            go = 1'b1;
            abort = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            go = 1'b0; abort = 1'b0;
            for (int k = 0; k < 300 && busy !== 1'b0; k++) begin
                spur_done = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
                abort     = ($urandom_range(0, 63) == 0);
                cfg_wr_en = ($urandom_range(0, 7) == 0);
                cfg_addr  = 2'($urandom_range(0, 3));
                cfg_data  = $urandom;
                @(negedge clk);
            end
            spur_done = '0; abort = 1'b0; cfg_wr_en = 1'b0;
            wait_idle(20, "rand_wait");
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
